// File: rtl/ysyx_axi4_mem_slave.sv
// ysyx_axi4_mem_slave: AXI4 word memory slave with independent read and
// write FSMs, one transaction outstanding each, configurable read latency.
module ysyx_axi4_mem_slave #(
  parameter int unsigned XLEN   = 32,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            arvalid,
  output logic            arready,
  input  logic [XLEN-1:0] araddr,
  input  logic [3:0]      arid,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  output logic            rvalid,
  input  logic            rready,
  output logic [XLEN-1:0] rdata,
  output logic [3:0]      rid,
  output logic [1:0]      rresp,
  output logic            rlast,
  input  logic            awvalid,
  output logic            awready,
  input  logic [XLEN-1:0] awaddr,
  input  logic [3:0]      awid,
  input  logic [7:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            wvalid,
  output logic            wready,
  input  logic [XLEN-1:0] wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  output logic            bvalid,
  input  logic            bready,
  output logic [3:0]      bid,
  output logic [1:0]      bresp
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH) << 2;

  function automatic logic in_rng(input logic [XLEN-1:0] a);
    logic [XLEN-1:0] off;
    off = a - BASE;
    return off < SPAN;
  endfunction

  function automatic logic [AW-1:0] widx(input logic [XLEN-1:0] a);
    logic [XLEN-1:0] off;
    off = (a - BASE) >> 2;
    return AW'(off);
  endfunction

  function automatic logic [XLEN-1:0] nxt(
    input logic [XLEN-1:0] a,
    input logic [2:0]      sz,
    input logic [1:0]      bu
  );
    return (bu == 2'b01) ? a + (XLEN'(1) << sz) : a;
  endfunction

  logic [XLEN-1:0] mem_q [DEPTH];

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;
  rstate_e rs_q, rs_d;
  logic [XLEN-1:0] raddr_q, raddr_d;
  logic [3:0]      rid_q, rid_d;
  logic [7:0]      rleft_q, rleft_d;
  logic [2:0]      rsize_q, rsize_d;
  logic [1:0]      rburst_q, rburst_d;
  logic [3:0]      rcnt_q, rcnt_d;
  logic            arready_q, rvalid_q, rlast_q;
  logic [XLEN-1:0] rdata_q;
  logic [1:0]      rresp_q;
  logic            rload, rerr;

  always_comb begin
    rs_d     = rs_q;
    raddr_d  = raddr_q;
    rid_d    = rid_q;
    rleft_d  = rleft_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rcnt_d   = rcnt_q;
    rload    = 1'b0;
    unique case (rs_q)
      R_IDLE: if (arvalid && arready_q) begin
        raddr_d  = araddr;
        rid_d    = arid;
        rleft_d  = arlen;
        rsize_d  = arsize;
        rburst_d = arburst;
        rcnt_d   = 4'(RD_LAT - 1);
        if (RD_LAT == 1) begin
          rs_d  = R_DATA;
          rload = 1'b1;
        end else begin
          rs_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rcnt_d = rcnt_q - 4'd1;
        if (rcnt_q == 4'd1) begin
          rs_d  = R_DATA;
          rload = 1'b1;
        end
      end
      R_DATA: if (rvalid_q && rready) begin
        if (rleft_q == 8'd0) begin
          rs_d = R_IDLE;
        end else begin
          rleft_d = rleft_q - 8'd1;
          raddr_d = nxt(raddr_q, rsize_q, rburst_q);
          rload   = 1'b1;
        end
      end
      default: rs_d = R_IDLE;
    endcase
    rerr = (rsize_d > 3'd2) || rburst_d[1] || !in_rng(raddr_d);
  end

  // Fetch happens at the edge the beat is loaded, so a same-cycle write
  // to the same word is not yet visible.
  always_ff @(posedge clock) begin
    if (reset) begin
      rs_q      <= R_IDLE;
      raddr_q   <= '0;
      rid_q     <= '0;
      rleft_q   <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      rs_q      <= rs_d;
      raddr_q   <= raddr_d;
      rid_q     <= rid_d;
      rleft_q   <= rleft_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      arready_q <= (rs_d == R_IDLE);
      rvalid_q  <= (rs_d == R_DATA);
      if (rload) begin
        rdata_q <= rerr ? '0 : mem_q[widx(raddr_d)];
        rresp_q <= rerr ? 2'b10 : 2'b00;
        rlast_q <= (rleft_d == 8'd0);
      end else if (rs_d != R_DATA) begin
        rlast_q <= 1'b0;
      end
    end
  end

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  wstate_e ws_q, ws_d;
  logic [XLEN-1:0] waddr_q, waddr_d;
  logic [3:0]      wid_q, wid_d;
  logic [7:0]      wleft_q, wleft_d;
  logic [2:0]      wsize_q, wsize_d;
  logic [1:0]      wburst_q, wburst_d;
  logic            werr_q, werr_d;
  logic            awready_q, wready_q, bvalid_q;
  logic [3:0]      bid_q;
  logic [1:0]      bresp_q;
  logic            wbad, wdo;

  always_comb begin
    ws_d     = ws_q;
    waddr_d  = waddr_q;
    wid_d    = wid_q;
    wleft_d  = wleft_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    werr_d   = werr_q;
    wbad     = 1'b0;
    wdo      = 1'b0;
    unique case (ws_q)
      W_IDLE: if (awvalid && awready_q) begin
        waddr_d  = awaddr;
        wid_d    = awid;
        wleft_d  = awlen;
        wsize_d  = awsize;
        wburst_d = awburst;
        werr_d   = 1'b0;
        ws_d     = W_DATA;
      end
      W_DATA: if (wvalid && wready_q) begin
        wbad = (wsize_q > 3'd2) || wburst_q[1] || !in_rng(waddr_q)
             || (wlast != (wleft_q == 8'd0));
        wdo    = !wbad;
        werr_d = werr_q | wbad;
        if (wleft_q == 8'd0) begin
          ws_d = W_RESP;
        end else begin
          wleft_d = wleft_q - 8'd1;
          waddr_d = nxt(waddr_q, wsize_q, wburst_q);
        end
      end
      W_RESP: if (bready) ws_d = W_IDLE;
      default: ws_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ws_q      <= W_IDLE;
      waddr_q   <= '0;
      wid_q     <= '0;
      wleft_q   <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      ws_q      <= ws_d;
      waddr_q   <= waddr_d;
      wid_q     <= wid_d;
      wleft_q   <= wleft_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      werr_q    <= werr_d;
      awready_q <= (ws_d == W_IDLE);
      wready_q  <= (ws_d == W_DATA);
      bvalid_q  <= (ws_d == W_RESP);
      if (ws_d == W_RESP && ws_q != W_RESP) begin
        bid_q   <= wid_q;
        bresp_q <= werr_d ? 2'b10 : 2'b00;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wdo && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[widx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rid     = rid_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
endmodule

// File: doc/ysyx_axi4_mem_slave.md
YSYX_AXI4_MEM_SLAVE -- requirements
Module: ysyx_axi4_mem_slave

Interface
REQ-001 Parameter XLEN, default 32; data/address width, only 32 supported.
REQ-002 Parameter BASE, default 32'h8000_0000; byte address of word 0.
REQ-003 Parameter DEPTH, default 1024; memory size in XLEN-bit words, power of two.
REQ-004 Parameter RD_LAT, default 1, range 1..15; cycles from AR handshake to first rvalid.
REQ-005 clock  in  1  single clock, all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 AR channel: arvalid in 1, arready out 1, araddr in XLEN, arid in 4, arlen in 8, arsize in 3, arburst in 2.
REQ-008 R channel: rvalid out 1, rready in 1, rdata out XLEN, rid out 4, rresp out 2, rlast out 1.
REQ-009 AW channel: awvalid in 1, awready out 1, awaddr in XLEN, awid in 4, awlen in 8, awsize in 3, awburst in 2.
REQ-010 W channel: wvalid in 1, wready out 1, wdata in XLEN, wstrb in 4, wlast in 1.
REQ-011 B channel: bvalid out 1, bready in 1, bid out 4, bresp out 2.

Function
REQ-012 Read and write paths are independent FSMs, each with one transaction outstanding; memory is a DEPTH-word array with one read and one write port.
REQ-013 Read FSM states: R_IDLE (arready=1), R_WAIT (latency countdown), R_DATA (rvalid=1); all outputs registered.
REQ-014 R_IDLE: on arvalid&arready, latch arid/araddr/arlen/arsize/arburst, load counter RD_LAT-1, go R_WAIT; if RD_LAT=1, go directly to R_DATA.
REQ-015 R_WAIT decrements each cycle and enters R_DATA when the counter reaches 0; first rvalid is exactly RD_LAT cycles after the AR handshake.
REQ-016 R_DATA: rdata, rid, rresp, rlast stay stable while rvalid=1 and rready=0.
REQ-017 On rvalid&rready with beats remaining, the next beat is presented the following cycle (zero wait); on the last beat, return to R_IDLE with arready=1 next cycle.
REQ-018 Beat count is arlen+1 (1..256); rlast=1 only on the final beat.
REQ-019 Beat address: INCR (2'b01) advances by (1<<arsize) per beat; FIXED (2'b00) holds; the word index is ((addr-BASE)>>2) mod DEPTH.
REQ-020 rdata is the full aligned word; sub-word extraction is the master's job.
REQ-021 rresp=SLVERR (2'b10) with rdata=0 for every beat when arsize>2, arburst=2'b1x, or any beat address lies outside [BASE, BASE+4*DEPTH); otherwise OKAY (2'b00).
REQ-022 Write FSM states: W_IDLE (awready=1, wready=0), W_DATA (wready=1), W_RESP (bvalid=1).
REQ-023 W_IDLE: on awvalid&awready, latch AW fields and go W_DATA; W beats arriving before the AW handshake wait (wready=0).
REQ-024 W_DATA: each wvalid&wready writes the bytes enabled by wstrb to the current beat address, then advances per REQ-019 rules.
REQ-025 After awlen+1 beats, go W_RESP; bresp=SLVERR if any beat was out of range, awsize>2, awburst=2'b1x, or wlast disagreed with beat position (early or missing); otherwise OKAY.
REQ-026 Beats flagged by the error conditions in REQ-025 do not modify memory; an early wlast does not end the burst early.
REQ-027 W_RESP: bvalid, bid and bresp stay stable until bready; then return to W_IDLE, with awready=1 the next cycle.
REQ-028 A read and a write to the same word in the same cycle: the read beat returns pre-write data.
REQ-029 rid and bid echo the latched arid and awid.

Reset
REQ-030 While reset=1: both FSMs go to IDLE, and arready, awready, wready, rvalid, bvalid, rlast=0; rdata, rid, rresp, bid, bresp=0.
REQ-031 arready and awready first assert in the cycle after reset deasserts.
REQ-032 Reset mid-burst abandons the transaction without a response, and completed writes stay in memory.
REQ-033 Memory contents are not cleared by reset.

Verification
REQ-034 Single write awaddr=BASE+8, wdata=32'hDEADBEEF, wstrb=4'hF, awlen=0 -> bvalid with bresp=00; then read araddr=BASE+8, RD_LAT=1 -> rvalid 1 cycle after AR, rdata=DEADBEEF, rlast=1.
REQ-035 Partial write wstrb=4'b0010, wdata=32'h0000AA00 over DEADBEEF -> read returns DEADAAEF.
REQ-036 INCR read arlen=3, arid=5, rready toggled 1/0 -> 4 beats at BASE..BASE+12, rid=5, rlast on beat 4 only, data held while rready=0.
REQ-037 Read araddr=BASE+4*DEPTH -> rresp=10, rdata=0; write with arsize/awsize=3 -> bresp=10 and memory unchanged.
REQ-038 W beats presented before AW -> wready stays 0 until the AW handshake; then 2-beat burst with wlast on beat 1 -> bresp=10, only beat 2 written.
REQ-039 Reset asserted during R_DATA of a 4-beat burst -> next cycle rvalid=0; after release, arready=1 and a new read completes normally.
